// File: rtl/round_ctrl.sv
// round_ctrl -- round sequencer for the digit-memory game.
//
// Seeds the rng once on the first start press. Each round it captures a
// 4-digit target code, shows it for SHOW_CYCLES, collects four player
// digits, compares them and updates score/lives. All outputs are registered.
//
// Optional feature: define ROUND_TIMEOUT_EN to abort an entry phase after
// TIMEOUT_CYCLES idle cycles (forced mismatch, so the round is lost).
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   debounced single-cycle start pulse
//   digit_valid   in   single-cycle pulse qualifying digit_in
//   digit_in[3:0] in   player digit (values >= 10 are ignored)
//   rng_d0..d3    in   digit outputs of the rng block
//   seed_en       out  seed request to rng (SEED state only)
//   code[15:0]    out  target code {d3,d2,d1,d0}
//   show          out  display must show code
//   entry_active  out  high in ENTRY
//   entry_count   out  accepted digits this round, 0..4
//   entered[15:0] out  accepted digits, shifted in from the LSB
//   win, lose     out  single-cycle result pulses
//   score[7:0]    out  rounds won, saturating at 255
//   lives[1:0]    out  remaining lives
//   state[2:0]    out  FSM encoding for debug/LEDs
module round_ctrl #(
  parameter int SHOW_CYCLES    = 100_000_000,
  parameter int RESULT_CYCLES  = 50_000_000,
  parameter int LIVES          = 3,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        digit_valid,
  input  logic [3:0]  digit_in,
  input  logic [3:0]  rng_d0,
  input  logic [3:0]  rng_d1,
  input  logic [3:0]  rng_d2,
  input  logic [3:0]  rng_d3,
  output logic        seed_en,
  output logic [15:0] code,
  output logic        show,
  output logic        entry_active,
  output logic [2:0]  entry_count,
  output logic [15:0] entered,
  output logic        win,
  output logic        lose,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEED     = 3'd1,
    LOAD     = 3'd2,
    SHOW     = 3'd3,
    ENTRY    = 3'd4,
    CHECK    = 3'd5,
    RESULT   = 3'd6,
    GAMEOVER = 3'd7
  } state_t;

  // One shared phase counter; sized for the longest interval it may time,
  // including the entry timeout, so both builds share the same datapath.
  localparam int MAX_A   = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic             seeded;
  logic             accept;
  logic             last_digit;
  logic             timeout;
  logic             match;

  assign accept     = (cur == ENTRY) && digit_valid && (digit_in <= 4'd9);
  assign last_digit = accept && (entry_count == 3'd3);

`ifdef ROUND_TIMEOUT_EN
  logic timed_out;  // forces a mismatch for a round aborted by the timeout

  assign timeout = (cur == ENTRY) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign match   = (entered == code) && !timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timed_out <= 1'b0;
    end else if (cur == LOAD) begin
      timed_out <= 1'b0;
    end else if (timeout && !last_digit) begin
      // A 4th digit on the timeout cycle takes priority: normal compare.
      timed_out <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign match   = (entered == code);
`endif

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // values from before the edge; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // Next-state logic
  // NOTE: nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:     if (start) nxt = seeded ? LOAD : SEED;
      SEED:     nxt = LOAD;
      LOAD:     if (cnt == CNT_W'(1)) nxt = SHOW;
      SHOW:     if (cnt == CNT_W'(SHOW_CYCLES - 1)) nxt = ENTRY;
      ENTRY:    if (last_digit || timeout) nxt = CHECK;
      CHECK:    nxt = RESULT;
      RESULT:   if (cnt == CNT_W'(RESULT_CYCLES - 1)) nxt = (lives == 2'd0) ? GAMEOVER : LOAD;
      GAMEOVER: if (start) nxt = LOAD;
      default:  nxt = IDLE;
    endcase
  end

  // Phase counter: restarts on every state change and on each accepted digit
  // (the latter only matters for the entry timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt <= '0;
    else if (nxt != cur || accept) cnt <= '0;
    else                           cnt <= cnt + CNT_W'(1);
  end

  // Registered datapath and outputs. Flag outputs are decoded from nxt so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seeded       <= 1'b0;
      seed_en      <= 1'b0;
      show         <= 1'b0;
      entry_active <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      code         <= '0;
      entered      <= '0;
      entry_count  <= '0;
      score        <= '0;
      lives        <= 2'(LIVES);
    end else begin
      seed_en      <= (nxt == SEED);
      show         <= (nxt == SHOW);
      entry_active <= (nxt == ENTRY);
      win          <= (cur == CHECK) && match;
      lose         <= (cur == CHECK) && !match;

      if (cur == SEED) seeded <= 1'b1;

      if (cur == LOAD && nxt == SHOW) begin
        code        <= {rng_d3, rng_d2, rng_d1, rng_d0};
        entered     <= '0;
        entry_count <= '0;
      end else if (accept) begin
        entered     <= {entered[11:0], digit_in};
        entry_count <= entry_count + 3'd1;
      end

      if (cur == CHECK) begin
        if (match) begin
          if (score != 8'hFF) score <= score + 8'd1;
        end else if (lives != 2'd0) begin
          lives <= lives - 2'd1;
        end
      end else if (cur == GAMEOVER && start) begin
        score <= '0;
        lives <= 2'(LIVES);
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl -- directed self-checking bench for round_ctrl.
// rng is stubbed to d0..d3 = 1,2,3,4, so the target code is 16'h4321.
// Define ROUND_TIMEOUT_EN for both files to exercise the entry timeout.
module tb_round_ctrl;

  localparam int SHOW_CYCLES    = 4;
  localparam int RESULT_CYCLES  = 2;
  localparam int LIVES          = 2;
  localparam int TIMEOUT_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic [3:0]  rng_d0 = 4'd1, rng_d1 = 4'd2, rng_d2 = 4'd3, rng_d3 = 4'd4;
  logic        seed_en, show, entry_active, win, lose;
  logic [15:0] code, entered;
  logic [2:0]  entry_count, state;
  logic [7:0]  score;
  logic [1:0]  lives;

  int checks = 0;
  int errors = 0;

  round_ctrl #(
    .SHOW_CYCLES(SHOW_CYCLES),
    .RESULT_CYCLES(RESULT_CYCLES),
    .LIVES(LIVES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid),
    .digit_in(digit_in), .rng_d0(rng_d0), .rng_d1(rng_d1), .rng_d2(rng_d2),
    .rng_d3(rng_d3), .seed_en(seed_en), .code(code), .show(show),
    .entry_active(entry_active), .entry_count(entry_count), .entered(entered),
    .win(win), .lose(lose), .score(score), .lives(lives), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic enter(input logic [3:0] d);
    digit_valid = 1'b1;
    digit_in    = d;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int bound);
    int n = 0;
    while (state != target && n < bound) begin
      step();
      n++;
    end
    check(tag, state, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 3'd0);
    check({tag, "_flags"}, {seed_en, show, entry_active, win, lose}, 5'd0);
    check({tag, "_code"}, code, 16'h0);
    check({tag, "_entered"}, entered, 16'h0);
    check({tag, "_count"}, entry_count, 3'd0);
    check({tag, "_score"}, score, 8'd0);
    check({tag, "_lives"}, lives, 2'd2);
  endtask

  initial begin
    int n;
    #12;
    check_reset_values("rst");
    rst = 1'b0;
    step();

    // 1: first start seeds for exactly one cycle, then LOAD x2, SHOW x4
    press_start();
    check("seed_state", state, 3'd1);
    check("seed_en_hi", seed_en, 1'b1);
    step();
    check("load1_state", state, 3'd2);
    check("seed_en_lo", seed_en, 1'b0);
    step();
    check("load2_state", state, 3'd2);
    step();
    check("show_state", state, 3'd3);
    check("code", code, 16'h4321);
    n = 0;
    while (show && n < 20) begin
      n++;
      step();
    end
    check("show_len", n, 4);
    check("entry_state", state, 3'd4);
    check("entry_active", entry_active, 1'b1);

    // 2: correct entry wins; next round skips SEED
    enter(4'd4); enter(4'd3); enter(4'd2); enter(4'd1);
    check("entered", entered, 16'h4321);
    check("check_state", state, 3'd5);
    step();
    check("win_pulse", win, 1'b1);
    check("win_state", state, 3'd6);
    check("score1", score, 8'd1);
    check("lives_win", lives, 2'd2);
    step();
    check("win_once", win, 1'b0);
    step();
    check("reload_state", state, 3'd2);
    check("no_reseed", seed_en, 1'b0);

    // 3: digit 12 is ignored
    wait_state("wait_entry3", 3'd4, 20);
    enter(4'd4);
    check("count_1", entry_count, 3'd1);
    enter(4'd12);
    check("count_ign", entry_count, 3'd1);
    enter(4'd3); enter(4'd2); enter(4'd1);
    step();
    check("win3", win, 1'b1);
    check("score2", score, 8'd2);

    // 4: two losses drain lives, GAMEOVER, restart
    for (int r = 0; r < 2; r++) begin
      wait_state("wait_entry4", 3'd4, 20);
      enter(4'd9); enter(4'd9); enter(4'd9); enter(4'd9);
      step();
      check("lose_pulse", lose, 1'b1);
      check("win_lo", win, 1'b0);
      check("lives_dec", lives, 2'(1 - r));
      check("score_kept", score, 8'd2);
      step();
      check("lose_once", lose, 1'b0);
    end
    wait_state("gameover", 3'd7, 10);
    step();
    check("gameover_hold", state, 3'd7);
    press_start();
    check("restart_state", state, 3'd2);
    check("restart_score", score, 8'd0);
    check("restart_lives", lives, 2'd2);
    check("restart_noseed", seed_en, 1'b0);

    // 5: asynchronous reset mid-entry
    wait_state("wait_entry5", 3'd4, 20);
    enter(4'd4); enter(4'd3);
    check("count_2", entry_count, 3'd2);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    #3;
    rst = 1'b0;
    step();
    press_start();
    check("reseed_state", state, 3'd1);
    check("reseed_en", seed_en, 1'b1);

`ifdef ROUND_TIMEOUT_EN
    // 6a: no digits for TIMEOUT_CYCLES -> forced loss
    wait_state("wait_entry6", 3'd4, 20);
    n = 0;
    while (!lose && n < 40) begin
      n++;
      step();
    end
    check("timeout_lose", lose, 1'b1);
    check("timeout_lives", lives, 2'd1);

    // 6b: 4th correct digit lands exactly on the timeout cycle -> win
    wait_state("wait_entry6b", 3'd4, 20);
    enter(4'd4); enter(4'd3); enter(4'd2);
    repeat (TIMEOUT_CYCLES - 1) step();
    check("edge_still_entry", state, 3'd4);
    enter(4'd1);
    step();
    check("edge_win", win, 1'b1);
    check("edge_lose", lose, 1'b0);
    check("edge_lives", lives, 2'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
